// File: rtl/pcie_write_mod.sv
// pcie_write_mod: streams FPGA words through a small FIFO into consecutive RAM addresses from a programmed base.
module pcie_write_mod #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] FPGA_data,
  input  logic              FPGA_valid,
  output logic              FPGA_ready,
  output logic [ADDR_W-1:0] RAM_addr,
  output logic [DATA_W-1:0] RAM_data,
  output logic              RAM_we,
  input  logic              RAM_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_written
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW:0] rd_ptr, wr_ptr;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W:0] target, accepted;
  logic full, empty, push, pop, load;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr - rd_ptr) == (PW+1)'(FIFO_DEPTH);
  assign load = state == IDLE && start;
  assign FPGA_ready = enable && state == RUN && !full && accepted < target;
  assign RAM_we = enable && !empty;
  assign RAM_data = mem[rd_ptr[PW-1:0]];
  assign RAM_addr = wptr;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign push = FPGA_valid && FPGA_ready;
  assign pop = RAM_we && RAM_ready;
  always_comb begin
    state_nx = state;
    if (state == IDLE)
      state_nx = start ? (length == '0 ? DONE : RUN) : IDLE;
    else if (state == RUN)
      state_nx = (pop && words_written + (ADDR_W+1)'(1) == target) ? DONE : RUN;
    else
      state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      wptr <= '0;
      target <= '0;
      accepted <= '0;
      words_written <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        wptr <= base_addr;
        target <= length;
        accepted <= '0;
        words_written <= '0;
      end
      if (push) begin
        mem[wr_ptr[PW-1:0]] <= FPGA_data;
        wr_ptr <= wr_ptr + 1'b1;
        accepted <= accepted + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        wptr <= wptr + 1'b1;
        words_written <= words_written + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pcie_write_mod.sv
// tb_pcie_write_mod: directed scenarios with randomized handshakes, checked every cycle against a transaction-level model.
module tb_pcie_write_mod;
  logic clk = 0, rst_n = 0, enable = 0, start = 0;
  logic [10:0] base_addr = 0;
  logic [11:0] length = 0;
  logic [31:0] FPGA_data = 0;
  logic FPGA_valid = 0, RAM_ready = 0;
  logic FPGA_ready, RAM_we, busy, done;
  logic [10:0] RAM_addr;
  logic [31:0] RAM_data;
  logic [11:0] words_written;
  pcie_write_mod dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
    .base_addr(base_addr), .length(length), .FPGA_data(FPGA_data),
    .FPGA_valid(FPGA_valid), .FPGA_ready(FPGA_ready), .RAM_addr(RAM_addr),
    .RAM_data(RAM_data), .RAM_we(RAM_we), .RAM_ready(RAM_ready),
    .busy(busy), .done(done), .words_written(words_written)
  );
  always #5 clk = ~clk;
  int passed = 0, fails = 0, total = 0;
  bit m_run, m_done, rnd;
  int m_base, m_len, m_acc, m_com, obs_acc, pv = 50, pr = 50;
  logic [31:0] m_q[$];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_run = 0; m_done = 0; m_base = 0; m_len = 0; m_acc = 0; m_com = 0;
    m_q.delete();
  endtask
  task automatic reset_outputs_chk();
    chk("rst_ready", FPGA_ready, 0);
    chk("rst_we", RAM_we, 0);
    chk("rst_addr", RAM_addr, 0);
    chk("rst_data", RAM_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ww", words_written, 0);
  endtask
  task automatic tick();
    bit er, ew, a, c;
    int occ;
    @(negedge clk);
    occ = m_acc - m_com;
    er = enable && m_run && occ < 4 && m_acc < m_len;
    ew = enable && occ > 0;
    chk("ready", FPGA_ready, er);
    chk("we", RAM_we, ew);
    chk("busy", busy, m_run || m_done);
    chk("done", done, m_done);
    chk("ww", words_written, m_com);
    if (ew && RAM_ready) begin
      chk("addr", RAM_addr, (m_base + m_com) % 2048);
      chk("data", RAM_data, m_q[m_com]);
    end
    if (FPGA_valid && FPGA_ready) obs_acc++;
    a = FPGA_valid && er;
    c = ew && RAM_ready;
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (start && !m_run && !m_done) begin
      m_base = base_addr; m_len = length; m_acc = 0; m_com = 0;
      m_q.delete();
      if (length == 0) m_done = 1; else m_run = 1;
    end else begin
      m_done = 0;
      if (a) begin m_q.push_back(FPGA_data); m_acc++; end
      if (c) begin
        m_com++;
        if (m_com == m_len) begin m_run = 0; m_done = 1; end
      end
    end
    #1;
    FPGA_data = $urandom;
    if (rnd) begin
      FPGA_valid = $urandom_range(99) < pv;
      RAM_ready = $urandom_range(99) < pr;
    end
  endtask
  task automatic go(input logic [10:0] b, input logic [11:0] l);
    base_addr = b; length = l; start = 1;
    tick();
    start = 0;
  endtask
  task automatic finish_xfer(input int limit);
    int n = 0;
    while (!m_done && n < limit) begin tick(); n++; end
    chk("timeout", m_done, 1);
    tick();
  endtask
  initial begin
    model_reset();
    #1;
    reset_outputs_chk();
    tick(); tick();
    rst_n = 1; enable = 1;
    // basic two-word transfer
    RAM_ready = 1;
    go(11'h000, 12'd2);
    FPGA_valid = 1; FPGA_data = 32'hfeadbeef;
    tick();
    FPGA_data = 32'hffffffff;
    tick();
    FPGA_valid = 0;
    finish_xfer(20);
    chk("basic_ww", words_written, 2);
    // wrap-around with random handshakes
    rnd = 1; pv = 70; pr = 70;
    go(11'h7FE, 12'd4);
    finish_xfer(200);
    chk("wrap_ww", words_written, 4);
    // back-pressure
    rnd = 0; FPGA_valid = 0;
    go(11'd5, 12'd8);
    FPGA_valid = 1; RAM_ready = 0; obs_acc = 0;
    repeat (10) tick();
    chk("bp_acc", obs_acc, 4);
    chk("bp_ready", FPGA_ready, 0);
    RAM_ready = 1;
    finish_xfer(100);
    chk("bp_ww", words_written, 8);
    // zero length
    FPGA_valid = 0;
    go(11'd3, 12'd0);
    chk("zero_done", done, 1);
    chk("zero_we", RAM_we, 0);
    tick();
    // start during RUN is ignored
    rnd = 1; pv = 60; pr = 60;
    go(11'd100, 12'd8);
    repeat (3) tick();
    base_addr = 11'd200; length = 12'd2; start = 1;
    tick();
    start = 0;
    finish_xfer(200);
    chk("ign_ww", words_written, 8);
    // pause via enable
    rnd = 0; FPGA_valid = 1; RAM_ready = 1;
    go(11'd50, 12'd6);
    repeat (3) tick();
    enable = 0;
    repeat (5) tick();
    enable = 1;
    finish_xfer(100);
    chk("pause_ww", words_written, 6);
    // reset mid-transfer
    go(11'd9, 12'd8);
    for (int n = 0; n < 20 && m_com < 3; n++) tick();
    chk("mid_com", words_written, 3);
    #2 rst_n = 0;
    #1;
    reset_outputs_chk();
    model_reset();
    tick(); tick();
    rst_n = 1;
    rnd = 1; pv = 80; pr = 50;
    go(11'h010, 12'd3);
    finish_xfer(100);
    chk("post_rst_ww", words_written, 3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
